// File: rtl/demod_pkg.sv
// Shared definitions for the AM demodulator control path.
//   - depth_state_t  : one-hot state encoding of the depth calculator FSM
//   - DEPTH_FRAC_WIDTH / AM_INPUT_WIDTH : default widths
//   - depth_sat()    : largest Q0.F value, used to saturate depth when m >= 1
package demod_pkg;

    localparam int AM_INPUT_WIDTH   = 13;
    localparam int DEPTH_FRAC_WIDTH = 10;

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_PREP = 4'b0010,
        ST_DIV  = 4'b0100,
        ST_DONE = 4'b1000
    } depth_state_t;

    function automatic logic [31:0] depth_sat(input int frac_width);
        return (32'd1 << frac_width) - 32'd1;
    endfunction

endpackage

// File: rtl/udiv_restoring.sv
// Serial restoring divider, one quotient bit per clock, MSB first.
// The dividend is loaded straight into the remainder, so the first step
// yields the 2^(QW-1) quotient bit and each following step shifts the
// remainder left by one; the result is floor(dividend * 2^(QW-1) / divisor)
// whenever dividend < 2 * divisor. If dividend >= divisor the top quotient
// bit is set, which the caller treats as overflow.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   start      : load dividend/divisor and begin (QW steps follow)
//   dividend   : unsigned dividend, DW bits
//   divisor    : unsigned divisor, DW bits
//   done       : high during the cycle whose edge performs the last step
//   quotient   : QW-bit quotient, final on the edge after done
module udiv_restoring #(
    parameter int DW = 14,
    parameter int QW = 11,
    parameter int RW = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic          done,
    output logic [QW-1:0] quotient
);

    localparam int CW = $clog2(QW);

    logic [RW-1:0] rem;
    logic [DW-1:0] dvs;
    logic [CW-1:0] cnt;
    logic          running;
    logic [RW:0]   trial;
    logic          q_bit;
    logic [RW-1:0] rem_step;

    // One extra bit so the sign of the trial subtraction is visible.
    assign trial    = {1'b0, rem} - {{(RW + 1 - DW){1'b0}}, dvs};
    assign q_bit    = ~trial[RW];
    assign rem_step = q_bit ? trial[RW-1:0] : rem;
    assign done     = running && (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem      <= '0;
            dvs      <= '0;
            cnt      <= '0;
            running  <= 1'b0;
            quotient <= '0;
        end else if (start) begin
            rem      <= {{(RW - DW){1'b0}}, dividend};
            dvs      <= divisor;
            cnt      <= CW'(QW - 1);
            running  <= 1'b1;
            quotient <= '0;
        end else if (running) begin
            quotient <= {quotient[QW-2:0], q_bit};
            rem      <= rem_step << 1;
            if (cnt == '0) begin
                running <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/am_depth_calc.sv
// AM envelope statistics from an averaged max/min pair: midpoint,
// half-amplitude and modulation depth m = (max-min)/(max+min) in Q0.F.
// Ports:
//   clk, rst_n         : clock, async active-low reset
//   in_valid           : one-cycle pulse, max_avg/min_avg valid
//   max_avg, min_avg   : signed averaged max/min
//   busy               : calculation in progress (state != IDLE)
//   dout_valid         : one-cycle pulse, result outputs updated
//   depth              : unsigned Q0.F depth, saturated to 2^F-1
//   midpoint/amplitude : signed (max+min)>>>1 and (max-min)>>>1
//   err                : sum <= 0 or max < min; depth forced to 0
//
// state | meaning
// IDLE  | waiting for in_valid
// PREP  | form diff/sum, screen error cases, start divider
// DIV   | divider stepping, one quotient bit per clock
// DONE  | register results; dout_valid follows on the next cycle
module am_depth_calc
    import demod_pkg::*;
#(
    parameter int INPUT_WIDTH = AM_INPUT_WIDTH,
    parameter int FRAC_WIDTH  = DEPTH_FRAC_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [INPUT_WIDTH-1:0] max_avg,
    input  logic [INPUT_WIDTH-1:0] min_avg,
    output logic                   busy,
    output logic                   dout_valid,
    output logic [FRAC_WIDTH-1:0]  depth,
    output logic [INPUT_WIDTH-1:0] midpoint,
    output logic [INPUT_WIDTH-1:0] amplitude,
    output logic                   err
);

    localparam logic [FRAC_WIDTH-1:0] DEPTH_MAX = FRAC_WIDTH'(depth_sat(FRAC_WIDTH));

    depth_state_t state, state_nxt;

    logic [INPUT_WIDTH-1:0] max_r, min_r;
    logic [INPUT_WIDTH:0]   diff, sum;
    logic                   err_calc;
    logic                   err_r;
    logic                   div_start;
    logic                   div_done;
    logic [FRAC_WIDTH:0]    quotient;
    logic [FRAC_WIDTH-1:0]  depth_nxt;

    // Sign-extend by one bit so neither sum nor difference can overflow.
    assign diff = {max_r[INPUT_WIDTH-1], max_r} - {min_r[INPUT_WIDTH-1], min_r};
    assign sum  = {max_r[INPUT_WIDTH-1], max_r} + {min_r[INPUT_WIDTH-1], min_r};

    assign err_calc  = sum[INPUT_WIDTH] || (sum == '0) || diff[INPUT_WIDTH];
    assign div_start = (state == ST_PREP) && !err_calc;
    assign busy      = (state != ST_IDLE);

    // Top quotient bit set means m >= 1.
    assign depth_nxt = err_r ? '0 :
                       (quotient[FRAC_WIDTH] ? DEPTH_MAX : quotient[FRAC_WIDTH-1:0]);

    udiv_restoring #(
        .DW(INPUT_WIDTH + 1),
        .QW(FRAC_WIDTH + 1),
        .RW(INPUT_WIDTH + 2)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (diff),
        .divisor  (sum),
        .done     (div_done),
        .quotient (quotient)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            // The cycle carrying dout_valid is not an accept slot.
            ST_IDLE: if (in_valid && !dout_valid) state_nxt = ST_PREP;
            ST_PREP: state_nxt = err_calc ? ST_DONE : ST_DIV;
            ST_DIV:  if (div_done) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_r      <= '0;
            min_r      <= '0;
            err_r      <= 1'b0;
            dout_valid <= 1'b0;
            depth      <= '0;
            midpoint   <= '0;
            amplitude  <= '0;
            err        <= 1'b0;
        end else begin
            dout_valid <= (state == ST_DONE);
            if (state == ST_IDLE && in_valid && !dout_valid) begin
                max_r <= max_avg;
                min_r <= min_avg;
            end
            if (state == ST_PREP) begin
                err_r <= err_calc;
            end
            if (state == ST_DONE) begin
                depth     <= depth_nxt;
                midpoint  <= sum[INPUT_WIDTH:1];
                amplitude <= diff[INPUT_WIDTH:1];
                err       <= err_r;
            end
        end
    end

endmodule

// File: tb/tb_am_depth_calc.sv
// Directed bench for am_depth_calc at INPUT_WIDTH=13, FRAC_WIDTH=10.
module tb_am_depth_calc;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic signed [12:0] max_avg, min_avg;
    logic               busy, dout_valid, err;
    logic [9:0]         depth;
    logic signed [12:0] midpoint, amplitude;

    int tests = 0;
    int fails = 0;
    int lat;
    int pulses;
    int first_lat;

    am_depth_calc #(.INPUT_WIDTH(13), .FRAC_WIDTH(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .max_avg    (max_avg),
        .min_avg    (min_avg),
        .busy       (busy),
        .dout_valid (dout_valid),
        .depth      (depth),
        .midpoint   (midpoint),
        .amplitude  (amplitude),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one sample, then return the number of edges from the
    // sampling edge to the edge that raises dout_valid (-1 on timeout).
    task automatic run_sample(input int mx, input int mn, output int latency);
        max_avg  = 13'(mx);
        min_avg  = 13'(mn);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("busy_after_accept", busy, 1);
        latency = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (dout_valid) begin
                latency = k;
                break;
            end
        end
    endtask

    task automatic check_result(input string tag, input int e_depth, input int e_mid,
                                input int e_amp, input int e_err);
        check({tag, "_depth"}, depth, e_depth);
        check({tag, "_mid"}, midpoint, e_mid);
        check({tag, "_amp"}, amplitude, e_amp);
        check({tag, "_err"}, err, e_err);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        max_avg  = '0;
        min_avg  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_dv", dout_valid, 0);
        check_result("rst", 0, 0, 0, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // m = 2000/4000 = 0.5
        run_sample(3000, 1000, lat);
        check("a_lat", lat, 13);
        check("a_busy_at_dv", busy, 0);
        check_result("a", 512, 2000, 1000, 0);
        @(posedge clk);
        #1;
        check("a_dv_pulse", dout_valid, 0);
        check("a_hold_depth", depth, 512);

        run_sample(2000, 2000, lat);
        check("b_lat", lat, 13);
        check_result("b", 0, 2000, 0, 0);
        @(posedge clk); #1;

        // diff == sum -> q = 1024, saturates
        run_sample(4000, 0, lat);
        check("c_lat", lat, 13);
        check_result("c", 1023, 2000, 2000, 0);
        @(posedge clk); #1;

        // floor(2999*1024/3001) = 1023
        run_sample(3000, 1, lat);
        check_result("d", 1023, 1500, 1499, 0);
        @(posedge clk); #1;

        // floor(2998*1024/3002) = 1022
        run_sample(3000, 2, lat);
        check_result("e", 1022, 1501, 1499, 0);
        @(posedge clk); #1;

        // sum == 0
        run_sample(1000, -1000, lat);
        check("f_lat", lat, 2);
        check_result("f", 0, 0, 1000, 1);
        @(posedge clk); #1;

        // max < min
        run_sample(100, 300, lat);
        check("g_lat", lat, 2);
        check_result("g", 0, 200, -100, 1);
        repeat (3) @(posedge clk);
        #1;
        check("g_hold_mid", midpoint, 200);
        check("g_hold_err", err, 1);

        // Second sample 5 clocks after the first must be dropped.
        max_avg  = 13'(3000);
        min_avg  = 13'(1000);
        in_valid = 1'b1;
        pulses    = 0;
        first_lat = -1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (dout_valid) begin
                pulses++;
                if (pulses == 1) first_lat = k - 1;
            end
            if (k == 5) begin
                max_avg  = 13'(1000);
                min_avg  = -13'sd1000;
                in_valid = 1'b1;
            end
        end
        check("drop_pulses", pulses, 1);
        check("drop_lat", first_lat, 13);
        check_result("drop", 512, 2000, 1000, 0);

        // in_valid in the dout_valid cycle is dropped too.
        run_sample(3000, 2, lat);
        max_avg  = 13'(1000);
        min_avg  = 13'(500);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("dv_cycle_drop_busy", busy, 0);
        check("dv_cycle_drop_depth", depth, 1022);

        // Reset in the middle of the division.
        run_sample(3000, 1000, lat);
        @(posedge clk); #1;
        max_avg  = 13'(3000);
        min_avg  = 13'(1000);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_dv", dout_valid, 0);
        check_result("abort", 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (dout_valid) pulses++;
        end
        check("abort_no_dv", pulses, 0);

        run_sample(3000, 2, lat);
        check("post_lat", lat, 13);
        check_result("post", 1022, 1501, 1499, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
